// File: rtl/elevator_scan.sv
// rtl/elevator_scan.sv - single-car SCAN elevator controller
//
// Purpose: latches car and hall calls, moves the car one floor per
// TRAVEL_CYCLES, opens the door for DOOR_CYCLES at served floors and keeps
// travelling in one direction while requests remain ahead (SCAN).
//
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous active-low reset
//   open_btn      - in-car door-open request (level)
//   close_btn     - in-car door-close request (level)
//   btn_in        - in-car floor calls, bit i = floor i
//   btn_up_out    - hall up calls (top bit ignored)
//   btn_down_out  - hall down calls (bit 0 ignored)
//   engine        - 00 stop, 01 up, 10 down
//   door          - 10 closed, 01 open
//   level_display - current floor index
//   dir_up        - service direction, 1 = up
//   pending       - OR of all latched requests
module elevator_scan #(
  parameter int FLOORS        = 8,
  parameter int LEVEL_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               open_btn,
  input  logic               close_btn,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-1:0]  btn_up_out,
  input  logic [FLOORS-1:0]  btn_down_out,
  output logic [1:0]         engine,
  output logic [1:0]         door,
  output logic [LEVEL_W-1:0] level_display,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  localparam logic [FLOORS-1:0] UP_VALID = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d, nxt_level;
  logic               dir_q, dir_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [FLOORS-1:0]  car_q, up_q, dn_q;
  logic [FLOORS-1:0]  car_d, up_d, dn_d;
  logic [1:0]         engine_q, engine_d;
  logic [1:0]         door_q, door_d;

  // Requests seen this cycle include the raw buttons, so a one-cycle pulse
  // is acted on by the same edge that latches it.
  logic [FLOORS-1:0] up_in_m, dn_in_m, car_e, up_e, dn_e, all_e, here_oh;
  assign up_in_m = btn_up_out & UP_VALID;
  assign dn_in_m = btn_down_out & DN_VALID;
  assign car_e   = car_q | btn_in;
  assign up_e    = up_q | up_in_m;
  assign dn_e    = dn_q | dn_in_m;
  assign all_e   = car_e | up_e | dn_e;

  function automatic logic ahead(input logic [LEVEL_W-1:0] n, input logic d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (d ? (i > int'(n)) : (i < int'(n))) r = r | all_e[i];
    end
    return r;
  endfunction

  function automatic logic hall(input logic [LEVEL_W-1:0] n, input logic d);
    return d ? up_e[n] : dn_e[n];
  endfunction

  // An opposite-direction hall call is only worth a stop when nothing lies
  // ahead; otherwise it waits for the return sweep.
  function automatic logic serve_here(input logic [LEVEL_W-1:0] n, input logic d);
    return car_e[n] | hall(n, d) | (hall(n, !d) & !ahead(n, d));
  endfunction

  // Direction the door opening serves: flips only to pick up an
  // opposite-direction call at the end of a sweep.
  function automatic logic serve_dir(input logic [LEVEL_W-1:0] n, input logic d);
    return (!hall(n, d) && hall(n, !d) && !ahead(n, d)) ? !d : d;
  endfunction

  assign nxt_level = (state_q == S_UP) ? level_q + LEVEL_W'(1) : level_q - LEVEL_W'(1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (open_btn || serve_here(level_q, dir_q)) begin
          state_d = S_DOOR;
          dcnt_d  = DW'(DOOR_CYCLES);
          dir_d   = serve_dir(level_q, dir_q);
        end else if (dir_q && ahead(level_q, 1'b1)) begin
          state_d = S_UP;
        end else if (ahead(level_q, 1'b0)) begin
          state_d = S_DOWN;
          dir_d   = 1'b0;
        end else if (ahead(level_q, 1'b1)) begin
          state_d = S_UP;
          dir_d   = 1'b1;
        end
      end
      S_UP, S_DOWN: begin
        if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
          tcnt_d  = '0;
          level_d = nxt_level;
          if (car_e[nxt_level] || hall(nxt_level, dir_q) || !ahead(nxt_level, dir_q)) begin
            state_d = S_DOOR;
            dcnt_d  = DW'(DOOR_CYCLES);
            dir_d   = serve_dir(nxt_level, dir_q);
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        if (open_btn || btn_in[level_q] || (dir_q ? up_in_m[level_q] : dn_in_m[level_q])) begin
          dcnt_d = DW'(DOOR_CYCLES);
        end else if (close_btn || dcnt_q == DW'(1)) begin
          // Leaving always passes through IDLE so the door reads closed for a
          // full cycle before the engine starts.
          state_d = S_IDLE;
          if (!ahead(level_q, dir_q) && ahead(level_q, !dir_q)) begin
            dir_d = !dir_q;
            if (hall(level_q, !dir_q)) begin
              state_d = S_DOOR;
              dcnt_d  = DW'(DOOR_CYCLES);
            end
          end
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
    endcase
  end

  // Clearing happens only at the floor the door is (or becomes) open at, so
  // a simultaneous set anywhere else survives.
  always_comb begin
    here_oh = '0;
    if (state_d == S_DOOR) here_oh[level_d] = 1'b1;
    car_d    = car_e & ~here_oh;
    up_d     = up_e & ~(dir_d ? here_oh : '0);
    dn_d     = dn_e & ~(dir_d ? '0 : here_oh);
    engine_d = (state_d == S_UP) ? 2'b01 : (state_d == S_DOWN) ? 2'b10 : 2'b00;
    door_d   = (state_d == S_DOOR) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      dir_q    <= 1'b1;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
      car_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      engine_q <= 2'b00;
      door_q   <= 2'b10;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
      car_q    <= car_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      engine_q <= engine_d;
      door_q   <= door_d;
    end
  end

  assign engine        = engine_q;
  assign door          = door_q;
  assign level_display = level_q;
  assign dir_up        = dir_q;
  assign pending       = car_q | up_q | dn_q;

endmodule

// File: tb/tb_elevator_scan.sv
// tb/tb_elevator_scan.sv - directed self-checking bench for elevator_scan
module tb_elevator_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       open_btn, close_btn;
  logic [7:0] btn_in, btn_up_out, btn_down_out;
  logic [1:0] engine, door;
  logic [2:0] level_display;
  logic       dir_up;
  logic [7:0] pending;

  logic       s_open, s_close;
  logic [3:0] s_in, s_up, s_dn;
  logic [1:0] s_engine, s_door;
  logic [1:0] s_level;
  logic       s_dir;
  logic [3:0] s_pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_scan #(.FLOORS(8), .LEVEL_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .open_btn(open_btn), .close_btn(close_btn),
    .btn_in(btn_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .engine(engine), .door(door), .level_display(level_display),
    .dir_up(dir_up), .pending(pending)
  );

  elevator_scan #(.FLOORS(4), .LEVEL_W(2), .TRAVEL_CYCLES(1), .DOOR_CYCLES(2)) dut_s (
    .clk(clk), .reset(reset), .open_btn(s_open), .close_btn(s_close),
    .btn_in(s_in), .btn_up_out(s_up), .btn_down_out(s_dn),
    .engine(s_engine), .door(s_door), .level_display(s_level),
    .dir_up(s_dir), .pending(s_pending)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; open_btn = 1'b0; close_btn = 1'b0;
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    s_open = 1'b0; s_close = 1'b0; s_in = '0; s_up = '0; s_dn = '0;
    tick(3);
    chk("rst_engine", engine, 2'b00);
    chk("rst_door", door, 2'b10);
    chk("rst_level", level_display, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_pending", pending, 0);
    reset = 1'b1;

    // Car call to top floor, first edge after release samples it
    btn_in = 8'h80; tick(1); btn_in = '0;
    chk("t7_engine_start", engine, 2'b01);
    chk("t7_pending", pending, 8'h80);
    tick(27);
    chk("t7_level6", level_display, 6);
    chk("t7_still_up", engine, 2'b01);
    tick(1);
    chk("t7_level7", level_display, 7);
    chk("t7_stop", engine, 2'b00);
    chk("t7_door_open", door, 2'b01);
    chk("t7_cleared", pending, 0);
    tick(7);
    chk("t7_door_last", door, 2'b01);
    tick(1);
    chk("t7_door_closed", door, 2'b10);

    // From 7: down hall at 3 and car call at 5
    btn_down_out = 8'h08; btn_in = 8'h20; tick(1); btn_down_out = '0; btn_in = '0;
    chk("d53_engine", engine, 2'b10);
    chk("d53_dir", dir_up, 0);
    chk("d53_pending", pending, 8'h28);
    tick(8);
    chk("d53_level5", level_display, 5);
    chk("d53_door5", door, 2'b01);
    chk("d53_pending5", pending, 8'h08);
    tick(7);
    chk("d53_door5_last", door, 2'b01);
    tick(1);
    chk("d53_door5_closed", door, 2'b10);
    chk("d53_gap_engine", engine, 2'b00);
    tick(1);
    chk("d53_restart", engine, 2'b10);
    tick(8);
    chk("d53_level3", level_display, 3);
    chk("d53_door3", door, 2'b01);
    chk("d53_pending3", pending, 0);
    tick(8);
    chk("d53_idle", door, 2'b10);

    // Held open button keeps door open well past DOOR_CYCLES
    open_btn = 1'b1; tick(12);
    chk("hold_door_mid", door, 2'b01);
    tick(8); open_btn = 1'b0;
    tick(6);
    chk("hold_door_tail", door, 2'b01);
    close_btn = 1'b1; tick(1); close_btn = 1'b0;
    chk("close_btn", door, 2'b10);
    open_btn = 1'b1; tick(1);
    chk("reopen", door, 2'b01);
    close_btn = 1'b1; tick(1);
    chk("open_wins", door, 2'b01);
    open_btn = 1'b0; tick(1); close_btn = 1'b0;
    chk("close_after", door, 2'b10);

    // Back to floor 0, then SCAN up with hall calls picked up on the way
    reset = 1'b0; tick(1); reset = 1'b1;
    chk("rst2_level", level_display, 0);
    btn_in = 8'h40; tick(1); btn_in = '0;
    chk("scan_engine", engine, 2'b01);
    tick(1);
    btn_up_out = 8'h04; btn_down_out = 8'h10; tick(1); btn_up_out = '0; btn_down_out = '0;
    chk("scan_pending", pending, 8'h54);
    tick(6);
    chk("scan_level2", level_display, 2);
    chk("scan_door2", door, 2'b01);
    chk("scan_pending2", pending, 8'h50);
    tick(9);
    chk("scan_restart", engine, 2'b01);
    tick(8);
    chk("scan_pass4", level_display, 4);
    chk("scan_pass4_engine", engine, 2'b01);
    tick(8);
    chk("scan_level6", level_display, 6);
    chk("scan_door6", door, 2'b01);
    chk("scan_dir6", dir_up, 1);
    chk("scan_pending6", pending, 8'h10);
    tick(8);
    chk("scan_rev_dir", dir_up, 0);
    tick(1);
    chk("scan_rev_engine", engine, 2'b10);
    tick(8);
    chk("scan_level4", level_display, 4);
    chk("scan_door4", door, 2'b01);
    chk("scan_dir4", dir_up, 0);
    chk("scan_pending4", pending, 0);
    tick(8);

    // Asynchronous reset between floors 3 and 2
    btn_in = 8'h01; tick(1); btn_in = '0;
    chk("mid_engine", engine, 2'b10);
    tick(4);
    chk("mid_level3", level_display, 3);
    tick(2);
    #3 reset = 1'b0;
    #1;
    chk("async_engine", engine, 2'b00);
    chk("async_door", door, 2'b10);
    chk("async_level", level_display, 0);
    chk("async_dir", dir_up, 1);
    chk("async_pending", pending, 0);
    tick(2); reset = 1'b1;
    tick(10);
    chk("post_rst_engine", engine, 2'b00);
    chk("post_rst_level", level_display, 0);
    chk("post_rst_pending", pending, 0);

    // Four-floor variant: ignored hall bits and floor bounds
    s_up = 4'h8; s_dn = 4'h1; tick(1); s_up = '0; s_dn = '0;
    chk("s_ignored_pending", s_pending, 0);
    chk("s_ignored_door", s_door, 2'b10);
    s_in = 4'h8; tick(1); s_in = '0;
    chk("s_up_engine", s_engine, 2'b01);
    tick(3);
    chk("s_top_level", s_level, 3);
    chk("s_top_stop", s_engine, 2'b00);
    chk("s_top_door", s_door, 2'b01);
    tick(2);
    chk("s_top_closed", s_door, 2'b10);
    s_up = 4'h8; tick(1); s_up = '0;
    tick(3);
    chk("s_top_hold", s_level, 3);
    chk("s_top_engine", s_engine, 2'b00);
    chk("s_top_pending", s_pending, 0);
    s_in = 4'h1; tick(1); s_in = '0;
    chk("s_dn_engine", s_engine, 2'b10);
    tick(3);
    chk("s_bot_level", s_level, 0);
    chk("s_bot_door", s_door, 2'b01);
    s_dn = 4'h1; tick(1); s_dn = '0;
    chk("s_bot_pending", s_pending, 0);
    tick(3);
    chk("s_bot_hold", s_level, 0);
    chk("s_bot_engine", s_engine, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
